// File: rtl/multi_rate_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : multi_rate_clock_divider
//  Description : Runtime-selectable clock divider. Produces a registered 50%
//                duty clkout whose half-period is one of four parameterised
//                values chosen by mode. Mode changes take effect only at a
//                period start, so no phase is ever shortened or stretched.
//                Optional feature macro: CLKDIV_TICK_EN builds the registered
//                one-cycle tick pulse on each clkout rise. Without it, tick is
//                tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_rate_clock_divider #(
    parameter int          CNT_W  = 26,
    parameter int unsigned HALF_0 = 10000,
    parameter int unsigned HALF_1 = 25000000,
    parameter int unsigned HALF_2 = 50000000,
    parameter int unsigned HALF_3 = 500000
) (
    input  logic       clkin,
    input  logic       rstn,
    input  logic       en,
    input  logic [1:0] mode,
    output logic       clkout,
    output logic       tick,
    output logic [1:0] mode_act
);

    // A half-period of zero cannot be counted, so it behaves as one cycle.
    localparam logic [CNT_W-1:0] HALF_0_EFF = (HALF_0 == 0) ? CNT_W'(1) : CNT_W'(HALF_0);
    localparam logic [CNT_W-1:0] HALF_1_EFF = (HALF_1 == 0) ? CNT_W'(1) : CNT_W'(HALF_1);
    localparam logic [CNT_W-1:0] HALF_2_EFF = (HALF_2 == 0) ? CNT_W'(1) : CNT_W'(HALF_2);
    localparam logic [CNT_W-1:0] HALF_3_EFF = (HALF_3 == 0) ? CNT_W'(1) : CNT_W'(HALF_3);

    logic [CNT_W-1:0] cnt;
    logic             period_start;
    logic [1:0]       sel_mode;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] half_m1;
    logic             terminal;

    // Pick the governing half-period: the requested mode only at a period
    // start, otherwise the mode latched at the last period start.
    always_comb begin
        period_start = (cnt == '0) && !clkout;
        sel_mode     = period_start ? mode : mode_act;
        half         = HALF_0_EFF;
        case (sel_mode)
            2'd0:    half = HALF_0_EFF;
            2'd1:    half = HALF_1_EFF;
            2'd2:    half = HALF_2_EFF;
            default: half = HALF_3_EFF;
        endcase
        half_m1  = half - CNT_W'(1);
        terminal = (cnt == half_m1);
    end

    // Phase counter, output clock and active-mode register; all frozen when en=0.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            clkout   <= 1'b0;
            mode_act <= 2'd0;
        end else if (en) begin
            if (period_start) begin
                mode_act <= mode;
            end
            if (terminal) begin
                cnt    <= '0;
                clkout <= ~clkout;
            end else begin
                cnt    <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef CLKDIV_TICK_EN
    // Pulse for the first cycle clkout is high after a low-to-high toggle.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            tick <= 1'b0;
        end else begin
            tick <= en && terminal && !clkout;
        end
    end
`else
    // Tick logic not built; the pin stays for footprint compatibility.
    assign tick = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_rate_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_rate_clock_divider
//  Description : Directed self-checking bench for multi_rate_clock_divider
//                with half-periods 2/3/5/1 and a 4-bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_rate_clock_divider;

`ifdef CLKDIV_TICK_EN
    localparam bit TICK_ON = 1'b1;
`else
    localparam bit TICK_ON = 1'b0;
`endif

    logic       clkin;
    logic       rstn;
    logic       en;
    logic [1:0] mode;
    logic       clkout;
    logic       tick;
    logic [1:0] mode_act;

    int tests_run;
    int tests_failed;

    multi_rate_clock_divider #(
        .CNT_W  (4),
        .HALF_0 (2),
        .HALF_1 (3),
        .HALF_2 (5),
        .HALF_3 (1)
    ) dut (
        .clkin    (clkin),
        .rstn     (rstn),
        .en       (en),
        .mode     (mode),
        .clkout   (clkout),
        .tick     (tick),
        .mode_act (mode_act)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Single comparison point: counts and reports mismatches.
    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cyc();
        @(posedge clkin);
        #1;
    endtask

    // Run n edges; bit i of clk_exp/tick_exp is the value after edge i+1.
    task automatic run_seq(input string tag, input int n,
                           input logic [31:0] clk_exp, input logic [31:0] tick_exp);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk($sformatf("%s clkout e%0d", tag, i + 1), {1'b0, clkout}, {1'b0, clk_exp[i]});
            chk($sformatf("%s tick e%0d", tag, i + 1), {1'b0, tick}, {1'b0, tick_exp[i] & TICK_ON});
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rstn = 1'b0;
        en   = 1'b0;
        mode = 2'd0;

        // Reset values
        #2;
        chk("reset clkout", {1'b0, clkout}, 2'd0);
        chk("reset tick", {1'b0, tick}, 2'd0);
        chk("reset mode_act", mode_act, 2'd0);

        @(negedge clkin);
        rstn = 1'b1;
        en   = 1'b1;
        mode = 2'd0;

        // Mode 0: 2 low / 2 high, first rise after 2 enabled edges
        run_seq("m0", 8, 32'h66, 32'h22);
        chk("m0 mode_act", mode_act, 2'd0);

        // Two more edges puts us in the high phase
        run_seq("m0b", 2, 32'h2, 32'h2);

        // Request mode 2 mid-high: current period completes unchanged
        mode = 2'd2;
        run_seq("sw_tail", 2, 32'h1, 32'h0);
        chk("sw mode_act before", mode_act, 2'd0);
        run_seq("sw_start", 1, 32'h0, 32'h0);
        chk("sw mode_act after", mode_act, 2'd2);
        // Remaining 4 low cycles, 5 high, then fall
        run_seq("m2", 9, 32'hF8, 32'h08);
        chk("m2 mode_act", mode_act, 2'd2);

        // Mode 1: 3 low, then first high cycle
        mode = 2'd1;
        run_seq("m1", 3, 32'h4, 32'h4);
        chk("m1 mode_act", mode_act, 2'd1);

        // Pause for 7 edges while high; a new mode request must wait
        en   = 1'b0;
        mode = 2'd3;
        run_seq("pause", 7, 32'h7F, 32'h0);
        chk("pause mode_act", mode_act, 2'd1);

        // Resume: exactly 2 more high cycles, then low
        en = 1'b1;
        run_seq("resume", 3, 32'h3, 32'h0);
        chk("resume mode_act", mode_act, 2'd1);

        // Mode 3 (H=1): toggle every edge, tick on every rise
        run_seq("m3", 5, 32'h15, 32'h15);
        chk("m3 mode_act", mode_act, 2'd3);

        // Asynchronous reset while clkout is high, between clock edges
        #2;
        rstn = 1'b0;
        #1;
        chk("async clkout", {1'b0, clkout}, 2'd0);
        chk("async tick", {1'b0, tick}, 2'd0);
        chk("async mode_act", mode_act, 2'd0);

        @(negedge clkin);
        rstn = 1'b1;
        mode = 2'd0;
        en   = 1'b1;

        // Mode 0 again for 20 edges after reset release
        run_seq("m0_long", 20, 32'h66666, 32'h22222);
        chk("m0_long mode_act", mode_act, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard time bound so the bench always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
